// File: rtl/imag_axis_framer.sv
// imag_axis_framer
// Turns a raw valid/ready pixel feed into AXI4-Stream video. tuser marks the
// first pixel of a frame (SOF), tlast marks the last pixel of each line (EOL).
// Pixels are tagged with their (x,y) position when accepted and then parked in
// a 2-entry skid FIFO, so tags never depend on output stalls and full rate is
// kept under backpressure.
//
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_enable          frame enable, only looked at while idle
//   s_pix_*           raw pixel input (data/valid/ready)
//   m_axis_*          framed AXI4-Stream output (tdata/tvalid/tready/tuser/tlast)
//   o_busy            a frame is in progress
//   o_frm_done        1-cycle pulse after the last pixel of a frame leaves
//
// Optional build macro IMAG_FRAMER_STAT_EN adds:
//   o_frm_cnt [15:0]  completed frame count (wrapping)
//   o_ovf_stall       sticky: source offered a pixel that could not be taken
module imag_axis_framer #(
    parameter int P_DATA_WIDTH = 24,
    parameter int P_IMG_WIDTH  = 1920,
    parameter int P_IMG_HEIGHT = 1080
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_enable,
    input  logic [P_DATA_WIDTH-1:0] s_pix_data,
    input  logic                    s_pix_valid,
    output logic                    s_pix_ready,
    output logic [P_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tuser,
    output logic                    m_axis_tlast,
    output logic                    o_busy,
    output logic                    o_frm_done
`ifdef IMAG_FRAMER_STAT_EN
    ,
    output logic [15:0]             o_frm_cnt,
    output logic                    o_ovf_stall
`endif
);

    // A height of 1 would give a zero-width y counter; keep at least one bit.
    localparam int XW = (P_IMG_WIDTH  > 1) ? $clog2(P_IMG_WIDTH)  : 1;
    localparam int YW = (P_IMG_HEIGHT > 1) ? $clog2(P_IMG_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(P_IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(P_IMG_HEIGHT - 1);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    // eof travels with the pixel so the frame end is recognised on the output
    // handshake rather than on the input accept.
    typedef struct packed {
        logic [P_DATA_WIDTH-1:0] data;
        logic                    sof;
        logic                    eol;
        logic                    eof;
    } entry_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          tag_done;   // all W*H pixels of this frame accepted

    entry_t        mem [2];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    cnt;

    entry_t        head, in_entry;
    logic          push, pop, frame_end;

    assign s_pix_ready = (state == S_ACTIVE) && !tag_done && (cnt != 2'd2);
    assign push        = s_pix_valid && s_pix_ready;
    assign pop         = m_axis_tvalid && m_axis_tready;
    assign head        = mem[rd_ptr];
    assign frame_end   = (state == S_ACTIVE) && pop && head.eof;

    assign in_entry.data = s_pix_data;
    assign in_entry.sof  = (x == '0) && (y == '0);
    assign in_entry.eol  = (x == X_LAST);
    assign in_entry.eof  = (x == X_LAST) && (y == Y_LAST);

    assign m_axis_tvalid = (cnt != 2'd0);
    assign m_axis_tdata  = head.data;
    assign m_axis_tuser  = head.sof;
    assign m_axis_tlast  = head.eol;
    assign o_busy        = (state == S_ACTIVE);

    // Frame control and pixel tagging. push and frame_end cannot coincide:
    // the frame end pops the last tag, after which no more pushes happen.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            x          <= '0;
            y          <= '0;
            tag_done   <= 1'b0;
            o_frm_done <= 1'b0;
        end else begin
            o_frm_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_enable) state <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (frame_end) begin
                        state      <= S_IDLE;
                        o_frm_done <= 1'b1;
                        tag_done   <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (push) begin
                if (x == X_LAST) begin
                    x <= '0;
                    if (y == Y_LAST) begin
                        y        <= '0;
                        tag_done <= 1'b1;
                    end else begin
                        y <= y + 1'b1;
                    end
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

    // 2-entry skid FIFO. Entries are reset so the outputs read 0 after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef IMAG_FRAMER_STAT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_frm_cnt   <= 16'd0;
            o_ovf_stall <= 1'b0;
        end else begin
            if (frame_end) o_frm_cnt <= o_frm_cnt + 16'd1;
            if ((state == S_ACTIVE) && s_pix_valid && !s_pix_ready) o_ovf_stall <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_imag_axis_framer.sv
module tb_imag_axis_framer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst, enable;
    logic [DW-1:0] s_pix_data;
    logic          s_pix_valid, s_pix_ready;
    logic [DW-1:0] tdata;
    logic          tvalid, tready, tuser, tlast, busy, frm_done;
`ifdef IMAG_FRAMER_STAT_EN
    logic [15:0]   frm_cnt;
    logic          ovf_stall;
`endif

    always #5 clk = ~clk;

    imag_axis_framer #(.P_DATA_WIDTH(DW), .P_IMG_WIDTH(W), .P_IMG_HEIGHT(H)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(enable),
        .s_pix_data(s_pix_data), .s_pix_valid(s_pix_valid), .s_pix_ready(s_pix_ready),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tuser(tuser), .m_axis_tlast(tlast),
        .o_busy(busy), .o_frm_done(frm_done)
`ifdef IMAG_FRAMER_STAT_EN
        , .o_frm_cnt(frm_cnt), .o_ovf_stall(ovf_stall)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Model: a pixel's tags follow only from its index within the frame.
    typedef struct packed {
        logic [DW-1:0] d;
        logic          sof, eol, eof;
    } exp_t;

    exp_t          q[$];
    int            idx = 0;
    logic          exp_done = 1'b0;
    logic          hold_v = 1'b0;
    logic [DW+1:0] hold_val;
    logic          acc_n = 1'b0;
    int            cyc = 0;
    int            done_seen = 0;
    int            full_seen = 0;
    logic [DW-1:0] log_d[$];
    logic          log_u[$], log_l[$];
    int            log_c[$], acc_c[$];

    // Feeder state, written by the main sequence only while the feeder is idle.
    int feed_left = 0;
    int nxt = 0;
    int rdy_mode = 0;   // 0: ready=1, 1: toggling, 2: ready=0

    // Single compare process: sample at negedge, then advance the model for
    // the handshakes the coming posedge will perform.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            idx = 0; exp_done = 1'b0; hold_v = 1'b0; acc_n = 1'b0;
        end else begin
            chk("frm_done", {31'd0, frm_done}, {31'd0, exp_done});
            if (exp_done) chk("busy_after_done", {31'd0, busy}, 32'd0);
            if (frm_done) done_seen++;
            exp_done = 1'b0;
            chk("tvalid_vs_occupancy", {31'd0, tvalid}, {31'd0, q.size() != 0});
            if (tvalid && q.size() != 0) begin
                chk("tdata", {8'd0, tdata}, {8'd0, q[0].d});
                chk("tuser", {31'd0, tuser}, {31'd0, q[0].sof});
                chk("tlast", {31'd0, tlast}, {31'd0, q[0].eol});
                chk("user_and_last", {31'd0, tuser && tlast}, 32'd0);
            end
            if (hold_v) chk("held_beat", {5'd0, tvalid, tdata, tuser, tlast}, {5'd0, 1'b1, hold_val});
            if (q.size() == 2) begin
                full_seen++;
                chk("ready_when_full", {31'd0, s_pix_ready}, 32'd0);
            end
            if (tvalid && tready && q.size() != 0) begin
                if (q[0].eof) exp_done = 1'b1;
                log_d.push_back(tdata); log_u.push_back(tuser);
                log_l.push_back(tlast); log_c.push_back(cyc);
                void'(q.pop_front());
            end
            acc_n = s_pix_valid && s_pix_ready;
            if (acc_n) begin
                q.push_back('{d: s_pix_data, sof: idx == 0, eol: (idx % W) == W - 1, eof: idx == W * H - 1});
                acc_c.push_back(cyc);
                idx = (idx + 1) % (W * H);
            end
            hold_v   = tvalid && !tready;
            hold_val = {tdata, tuser, tlast};
        end
    end

    initial begin
        s_pix_valid = 1'b0; s_pix_data = '0; tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (acc_n) begin
                feed_left = feed_left - 1;
                nxt = nxt + 1;
            end
            s_pix_valid = (feed_left > 0);
            s_pix_data  = DW'(nxt);
            case (rdy_mode)
                0:       tready = 1'b1;
                1:       tready = ~tready;
                default: tready = 1'b0;
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_dones(input int target, input string nm);
        int k = 0;
        while (done_seen < target && k < 300) begin tick(1); k++; end
        chk(nm, {31'd0, done_seen >= target}, 32'd1);
    endtask

    task automatic wait_busy_then_disable(input string nm);
        int k = 0;
        while (!busy && k < 50) begin tick(1); k++; end
        chk(nm, {31'd0, busy}, 32'd1);
        enable = 1'b0;
    endtask

    task automatic clear_logs();
        log_d.delete(); log_u.delete(); log_l.delete(); log_c.delete(); acc_c.delete();
    endtask

    task automatic start(input int n, input int first);
        nxt = first; feed_left = n; enable = 1'b1;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_tvalid"}, {31'd0, tvalid}, 32'd0);
        chk({nm, "_ready"},  {31'd0, s_pix_ready}, 32'd0);
        chk({nm, "_flags"},  {29'd0, tuser, tlast, frm_done}, 32'd0);
        chk({nm, "_busy"},   {31'd0, busy}, 32'd0);
        chk({nm, "_tdata"},  {8'd0, tdata}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    int base, k, nu;

    initial begin
        rst = 1'b1; enable = 1'b0;
        #23;
        check_reset_outputs("reset");
        @(negedge clk); rst = 1'b0;
        tick(2);
        chk("idle_ready", {31'd0, s_pix_ready}, 32'd0);

        // Basic frame at full rate
        clear_logs(); base = done_seen;
        start(8, 1);
        wait_busy_then_disable("basic_busy");
        wait_dones(base + 1, "basic_done");
        chk("basic_beats", log_d.size(), 8);
        if (log_d.size() == 8) begin
            nu = 0;
            foreach (log_u[i]) nu += log_u[i];
            chk("basic_b1", {7'd0, log_d[0], log_u[0]}, {7'd0, 24'h000001, 1'b1});
            chk("basic_b4_last", {31'd0, log_l[3]}, 32'd1);
            chk("basic_b8", {7'd0, log_d[7], log_l[7]}, {7'd0, 24'h000008, 1'b1});
            chk("basic_sof_count", nu, 1);
            chk("basic_full_rate", log_c[7] - log_c[0], 7);
            chk("basic_latency", log_c[0] - acc_c[0], 1);
        end
        tick(3);
        chk("basic_idle", {31'd0, busy}, 32'd0);

        // Backpressure: tready toggling
        clear_logs(); base = done_seen; full_seen = 0;
        rdy_mode = 1;
        start(8, 'h11);
        wait_busy_then_disable("bp_busy");
        wait_dones(base + 1, "bp_done");
        chk("bp_beats", log_d.size(), 8);
        if (log_d.size() == 8) chk("bp_first_last", {log_d[0][15:0], log_d[7][15:0]}, {16'h0011, 16'h0018});
        chk("bp_full_reached", {31'd0, full_seen > 0}, 32'd1);
        rdy_mode = 0;
        tick(3);

        // Back-to-back frames
        clear_logs(); base = done_seen;
        start(16, 1);
        wait_dones(base + 1, "b2b_done1");
        tick(1);
        chk("b2b_gap", {31'd0, busy}, 32'd1);
        enable = 1'b0;
        wait_dones(base + 2, "b2b_done2");
        chk("b2b_beats", log_d.size(), 16);
        if (log_d.size() == 16) begin
            chk("b2b_sof1", {31'd0, log_u[0]}, 32'd1);
            chk("b2b_sof9", {7'd0, log_d[8], log_u[8]}, {7'd0, 24'h000009, 1'b1});
            chk("b2b_no_sof", {31'd0, log_u[4] | log_u[12]}, 32'd0);
        end
        tick(3);

        // Disable mid-frame
        clear_logs(); base = done_seen;
        start(16, 'h40);
        k = 0;
        while (acc_c.size() < 3 && k < 50) begin tick(1); k++; end
        enable = 1'b0;
        wait_dones(base + 1, "dis_done");
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("dis_ready_low", {31'd0, s_pix_ready}, 32'd0);
        end
        chk("dis_beats", log_d.size(), 8);
        chk("dis_no_restart", {31'd0, busy}, 32'd0);
        feed_left = 0;
        tick(3);

        // Reset mid-frame
        clear_logs(); base = done_seen;
        start(20, 'h80);
        k = 0;
        while (log_d.size() < 5 && k < 50) begin tick(1); k++; end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        clear_logs();
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_busy_then_disable("rst_busy");
        wait_dones(base + 1, "rst_done");
        chk("rst_beats", log_d.size(), 8);
        if (log_d.size() == 8) begin
            chk("rst_sof", {31'd0, log_u[0]}, 32'd1);
            chk("rst_x_restart", {30'd0, log_l[2], log_l[3]}, 32'd1);
        end
        feed_left = 0;
        tick(3);

`ifdef IMAG_FRAMER_STAT_EN
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk); @(posedge clk); #1; rst = 1'b0;
        tick(1);
        for (int f = 0; f < 3; f++) begin
            base = done_seen;
            start(8, 'h100 + 8 * f);
            wait_busy_then_disable("stat_busy");
            wait_dones(base + 1, "stat_done");
            tick(2);
        end
        chk("stat_cnt3", {16'd0, frm_cnt}, 32'd3);
        chk("stat_no_ovf", {31'd0, ovf_stall}, 32'd0);
        base = done_seen;
        rdy_mode = 2;
        start(8, 'h200);
        wait_busy_then_disable("ovf_busy");
        tick(8);
        chk("ovf_set", {31'd0, ovf_stall}, 32'd1);
        rdy_mode = 0;
        wait_dones(base + 1, "ovf_done");
        tick(3);
        chk("ovf_sticky", {31'd0, ovf_stall}, 32'd1);
        chk("stat_cnt4", {16'd0, frm_cnt}, 32'd4);
        @(posedge clk); #1; rst = 1'b1; #1;
        chk("stat_rst", {15'd0, frm_cnt, ovf_stall}, 32'd0);
        @(negedge clk); @(posedge clk); #1; rst = 1'b0;
        tick(2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
